// File: rtl/csi2_packetizer.sv
// CSI-2 packetizer for a 2-lane byte interface: SoT sync, packet header with ECC,
// RAW payload with CRC-16 footer for line packets, then an LP gap.
module csi2_packetizer #(
    parameter int         NUM_LANES  = 2,
    parameter logic [5:0] DATA_TYPE  = 6'h2A,
    parameter logic [1:0] VC         = 2'd0,
    parameter int         GAP_CYCLES = 8
) (
    input  logic                   clk_byte,
    input  logic                   RESETn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_type,
    input  logic [15:0]            cmd_word_count,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_LANES*8-1:0] in_data,
    output logic [NUM_LANES*8-1:0] lane_data,
    output logic                   lane_valid,
    output logic [15:0]            frame_number,
    output logic                   cmd_err
);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_HEADER, S_PAYLOAD, S_CRC, S_GAP} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            cnt_q, fnum_q, crc_q, wc_q;
    logic [NUM_LANES*8-1:0] last_q;
    logic [1:0]             pkt_type_q;
    logic                   alive_q, cmd_err_q;
    logic                   accept, cmd_bad, start;
    logic [5:0]             dt;
    logic [7:0]             di, ecc;
    logic [15:0]            hdr_wc;

    function automatic logic [7:0] ecc_calc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return {2'b00, p};
    endfunction

    // Reflected CCITT polynomial (0x1021 bit-reversed), one byte LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign cmd_ready    = alive_q && (state_q == S_IDLE);
    assign accept       = cmd_valid && cmd_ready;
    assign cmd_bad      = (cmd_type == 2'd3) ||
                          ((cmd_type == 2'd2) && ((cmd_word_count == 16'd0) || cmd_word_count[0]));
    assign start        = accept && !cmd_bad;
    assign frame_number = fnum_q;
    assign cmd_err      = cmd_err_q;

    always_ff @(posedge clk_byte or negedge RESETn) begin
        if (!RESETn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_SYNC;
            S_SYNC:    state_d = S_HEADER;
            S_HEADER:  if (cnt_q[0]) state_d = (pkt_type_q == 2'd2) ? S_PAYLOAD : S_GAP;
            S_PAYLOAD: if (in_valid && (cnt_q == {1'b0, wc_q[15:1]} - 16'd1)) state_d = S_CRC;
            S_CRC:     state_d = S_GAP;
            S_GAP:     if (cnt_q == 16'(GAP_CYCLES - 1)) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // cnt_q restarts on every state change; in PAYLOAD it counts handshakes only.
    always_ff @(posedge clk_byte or negedge RESETn) begin
        if (!RESETn) begin
            cnt_q      <= 16'd0;
            alive_q    <= 1'b0;
            cmd_err_q  <= 1'b0;
            pkt_type_q <= 2'd0;
            fnum_q     <= 16'd0;
            crc_q      <= 16'hFFFF;
        end else begin
            alive_q   <= 1'b1;
            cmd_err_q <= accept && cmd_bad;
            if (state_d != state_q)                        cnt_q <= 16'd0;
            else if ((state_q != S_PAYLOAD) || in_valid)   cnt_q <= cnt_q + 16'd1;
            if (start) begin
                pkt_type_q <= cmd_type;
                crc_q      <= 16'hFFFF;
                if (cmd_type == 2'd0) fnum_q <= (fnum_q == 16'hFFFF) ? 16'd1 : fnum_q + 16'd1;
            end else if ((state_q == S_PAYLOAD) && in_valid) begin
                crc_q <= crc16_byte(crc16_byte(crc_q, in_data[7:0]), in_data[15:8]);
            end
        end
    end

    always_ff @(posedge clk_byte) begin
        if (start) begin
            wc_q   <= cmd_word_count;
            last_q <= '0;
        end else if ((state_q == S_PAYLOAD) && in_valid) begin
            last_q <= in_data;
        end
    end

    always_comb begin
        case (pkt_type_q)
            2'd0:    dt = 6'h00;
            2'd1:    dt = 6'h01;
            default: dt = DATA_TYPE;
        endcase
        di     = {VC, dt};
        hdr_wc = (pkt_type_q == 2'd2) ? wc_q : fnum_q;
        ecc    = ecc_calc({hdr_wc, di});
    end

    always_comb begin
        lane_valid = 1'b0;
        lane_data  = '0;
        in_ready   = 1'b0;
        case (state_q)
            S_SYNC: begin
                lane_valid = 1'b1;
                lane_data  = {8'hB8, 8'hB8};
            end
            S_HEADER: begin
                lane_valid = 1'b1;
                lane_data  = cnt_q[0] ? {ecc, hdr_wc[15:8]} : {hdr_wc[7:0], di};
            end
            S_PAYLOAD: begin
                lane_valid = 1'b1;
                in_ready   = 1'b1;
                lane_data  = in_valid ? in_data : last_q;
            end
            S_CRC: begin
                lane_valid = 1'b1;
                lane_data  = crc_q;
            end
            default: ;
        endcase
    end

endmodule
